// File: rtl/wb_stage_if.sv
// MEM -> WB handshake bundle: one completed instruction per transfer (mem_valid && mem_ready).
// The MEM stage uses the master modport; the writeback stage uses the slave modport.
interface wb_stage_if;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic        mem_is_load;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_data;

    modport master (
        output mem_valid,
        output mem_reg_write,
        output mem_rd,
        output mem_is_load,
        output mem_funct3,
        output mem_addr_lo,
        output mem_alu_result,
        output mem_load_data,
        input  mem_ready
    );

    modport slave (
        input  mem_valid,
        input  mem_reg_write,
        input  mem_rd,
        input  mem_is_load,
        input  mem_funct3,
        input  mem_addr_lo,
        input  mem_alu_result,
        input  mem_load_data,
        output mem_ready
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: load extraction, 2-entry write buffer ahead of a shared register-file port,
// and an optional pending-write scoreboard enabled by defining WB_SCOREBOARD_EN.
module wb_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    wb_stage_if.slave   mem,
    input  logic        rf_port_busy,
    output logic        reg_write_en,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    input  logic        sb_set_en,
    input  logic [4:0]  sb_set_reg,
    output logic [31:0] busy_mask
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    logic [1:0]  count_reg;
    logic [1:0]  count_next;
    logic        head_reg;
    logic        head_next;
    logic        wr_ptr;
    logic [4:0]  entry_rd_reg   [DEPTH];
    logic [31:0] entry_data_reg [DEPTH];

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_value;
    logic [31:0] push_data;

    logic        accept;
    logic        push;
    logic        pop;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    // Load data extraction; mem_addr_lo[0] does not affect halfword selection.
    always_comb begin
        load_byte = mem.mem_load_data[7:0];
        case (mem.mem_addr_lo)
            2'd0:    load_byte = mem.mem_load_data[7:0];
            2'd1:    load_byte = mem.mem_load_data[15:8];
            2'd2:    load_byte = mem.mem_load_data[23:16];
            default: load_byte = mem.mem_load_data[31:24];
        endcase
        load_half = mem.mem_addr_lo[1] ? mem.mem_load_data[31:16] : mem.mem_load_data[15:0];

        case (mem.mem_funct3)
            3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_value = {{16{load_half[15]}}, load_half};
            3'b100:  load_value = {24'h000000, load_byte};
            3'b101:  load_value = {16'h0000, load_half};
            default: load_value = mem.mem_load_data;
        endcase

        push_data = mem.mem_is_load ? load_value : mem.mem_alu_result;
    end

    // Ready depends only on the occupancy count, never on the downstream port.
    assign mem.mem_ready = (count_reg < FULL_COUNT);

    assign accept    = mem.mem_valid && mem.mem_ready;
    assign push      = accept && mem.mem_reg_write && (mem.mem_rd != 5'd0);
    assign pop       = (count_reg != 2'd0) && !rf_port_busy;
    assign head_rd   = entry_rd_reg[head_reg];
    assign head_data = entry_data_reg[head_reg];

    // A push only happens with count 0 or 1, so the tail is head offset by count[0].
    assign wr_ptr     = head_reg ^ count_reg[0];
    assign head_next  = pop ? ~head_reg : head_reg;
    assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= 2'd0;
            head_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            head_reg  <= head_next;
        end
    end

    // Payload storage carries no reset; validity is tracked by count_reg alone.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr == 1'(gi))) begin
                    entry_rd_reg[gi]   <= mem.mem_rd;
                    entry_data_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_write_en <= 1'b0;
            write_reg    <= 5'd0;
            write_data   <= 32'd0;
        end else begin
            reg_write_en <= pop;
            if (pop) begin
                write_reg  <= head_rd;
                write_data <= head_data;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:1] busy_mask_reg;

    // Set and clear share an edge; a set on the committing register keeps it busy.
    generate
        for (gi = 1; gi < 32; gi++) begin : g_sb
            logic set_hit;
            logic clr_hit;
            assign set_hit = sb_set_en && (sb_set_reg == 5'(gi));
            assign clr_hit = pop && (head_rd == 5'(gi));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    busy_mask_reg[gi] <= 1'b0;
                end else if (set_hit) begin
                    busy_mask_reg[gi] <= 1'b1;
                end else if (clr_hit) begin
                    busy_mask_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign busy_mask = {busy_mask_reg, 1'b0};
`else
    logic unused_sb;
    assign unused_sb = &{1'b0, sb_set_en, sb_set_reg};
    assign busy_mask = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: load extraction, latency, backpressure, x0 drop, scoreboard, reset.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rf_port_busy;
    logic        reg_write_en;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        sb_set_en;
    logic [4:0]  sb_set_reg;
    logic [31:0] busy_mask;

    int errors = 0;
    int checks = 0;

`ifdef WB_SCOREBOARD_EN
    localparam bit SB_ON = 1'b1;
`else
    localparam bit SB_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    wb_stage_if mem_bus ();

    wb_stage #(.DEPTH(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem          (mem_bus),
        .rf_port_busy (rf_port_busy),
        .reg_write_en (reg_write_en),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .sb_set_en    (sb_set_en),
        .sb_set_reg   (sb_set_reg),
        .busy_mask    (busy_mask)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("check %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rd, input logic rw, input logic ld,
                         input logic [2:0] f3, input logic [1:0] lo,
                         input logic [31:0] alu, input logic [31:0] ldd);
        mem_bus.mem_valid      = 1'b1;
        mem_bus.mem_rd         = rd;
        mem_bus.mem_reg_write  = rw;
        mem_bus.mem_is_load    = ld;
        mem_bus.mem_funct3     = f3;
        mem_bus.mem_addr_lo    = lo;
        mem_bus.mem_alu_result = alu;
        mem_bus.mem_load_data  = ldd;
    endtask

    task automatic idle();
        mem_bus.mem_valid = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        rf_port_busy = 1'b0;
        sb_set_en    = 1'b0;
        sb_set_reg   = 5'd0;
        drive(5'd0, 1'b0, 1'b0, 3'b000, 2'd0, 32'd0, 32'd0);
        idle();
        step();
        step();

        // Reset state
        check("rst_en", 32'(reg_write_en), 32'd0);
        check("rst_reg", 32'(write_reg), 32'd0);
        check("rst_data", write_data, 32'd0);
        check("rst_mask", busy_mask, 32'd0);
        check("rst_ready", 32'(mem_bus.mem_ready), 32'd1);
        reset_n = 1'b1;
        step();

        // LB sign extension, two-edge latency
        drive(5'd4, 1'b1, 1'b1, 3'b000, 2'd2, 32'd0, 32'h12F45678);
        step();
        idle();
        check("lb_lat_en", 32'(reg_write_en), 32'd0);
        step();
        check("lb_en", 32'(reg_write_en), 32'd1);
        check("lb_reg", 32'(write_reg), 32'd4);
        check("lb_data", write_data, 32'hFFFFFFF4);
        step();
        check("lb_idle_en", 32'(reg_write_en), 32'd0);
        check("lb_hold_data", write_data, 32'hFFFFFFF4);

        // Back-to-back loads: LHU, LH (addr_lo[0] ignored), LBU
        drive(5'd10, 1'b1, 1'b1, 3'b101, 2'd2, 32'd0, 32'h8001ABCD);
        step();
        drive(5'd11, 1'b1, 1'b1, 3'b001, 2'd1, 32'd0, 32'h8001ABCD);
        step();
        check("lhu_reg", 32'(write_reg), 32'd10);
        check("lhu_data", write_data, 32'h00008001);
        drive(5'd12, 1'b1, 1'b1, 3'b100, 2'd3, 32'd0, 32'h80123456);
        step();
        idle();
        check("lh_en", 32'(reg_write_en), 32'd1);
        check("lh_reg", 32'(write_reg), 32'd11);
        check("lh_data", write_data, 32'hFFFFABCD);
        step();
        check("lbu_reg", 32'(write_reg), 32'd12);
        check("lbu_data", write_data, 32'h00000080);
        step();
        check("b2b_idle_en", 32'(reg_write_en), 32'd0);

        // Backpressure: port busy, three ALU results
        rf_port_busy = 1'b1;
        drive(5'd5, 1'b1, 1'b0, 3'b010, 2'd0, 32'h00000055, 32'hDEADBEEF);
        check("bp_ready0", 32'(mem_bus.mem_ready), 32'd1);
        step();
        drive(5'd6, 1'b1, 1'b0, 3'b010, 2'd0, 32'h00000066, 32'hDEADBEEF);
        check("bp_ready1", 32'(mem_bus.mem_ready), 32'd1);
        step();
        drive(5'd7, 1'b1, 1'b0, 3'b010, 2'd0, 32'h00000077, 32'hDEADBEEF);
        check("bp_ready2", 32'(mem_bus.mem_ready), 32'd0);
        step();
        check("bp_full_ready", 32'(mem_bus.mem_ready), 32'd0);
        check("bp_full_en", 32'(reg_write_en), 32'd0);
        step();
        check("bp_hold_en", 32'(reg_write_en), 32'd0);
        rf_port_busy = 1'b0;
        step();
        check("bp_w5_en", 32'(reg_write_en), 32'd1);
        check("bp_w5_reg", 32'(write_reg), 32'd5);
        check("bp_w5_data", write_data, 32'h00000055);
        check("bp_ready_back", 32'(mem_bus.mem_ready), 32'd1);
        step();
        idle();
        check("bp_w6_en", 32'(reg_write_en), 32'd1);
        check("bp_w6_reg", 32'(write_reg), 32'd6);
        check("bp_w6_data", write_data, 32'h00000066);
        step();
        check("bp_w7_en", 32'(reg_write_en), 32'd1);
        check("bp_w7_reg", 32'(write_reg), 32'd7);
        check("bp_w7_data", write_data, 32'h00000077);
        step();
        check("bp_no_dup", 32'(reg_write_en), 32'd0);

        // x0 and no-write instructions are accepted but dropped
        drive(5'd0, 1'b1, 1'b0, 3'b010, 2'd0, 32'h0000DEAD, 32'd0);
        check("x0_ready", 32'(mem_bus.mem_ready), 32'd1);
        step();
        drive(5'd9, 1'b0, 1'b0, 3'b010, 2'd0, 32'h0000BEEF, 32'd0);
        check("nw_ready", 32'(mem_bus.mem_ready), 32'd1);
        step();
        idle();
        check("x0_en_a", 32'(reg_write_en), 32'd0);
        step();
        check("x0_en_b", 32'(reg_write_en), 32'd0);
        step();
        check("x0_en_c", 32'(reg_write_en), 32'd0);
        check("x0_hold_reg", 32'(write_reg), 32'd7);

        // Scoreboard: set, x0 ignored, set-wins on commit, plain clear
        sb_set_en  = 1'b1;
        sb_set_reg = 5'd3;
        step();
        sb_set_en = 1'b0;
        check("sb_set3", busy_mask, SB_ON ? 32'h00000008 : 32'h0);
        sb_set_en  = 1'b1;
        sb_set_reg = 5'd0;
        step();
        sb_set_en = 1'b0;
        check("sb_x0_ignored", busy_mask, SB_ON ? 32'h00000008 : 32'h0);
        drive(5'd3, 1'b1, 1'b0, 3'b010, 2'd0, 32'h00000033, 32'd0);
        step();
        idle();
        sb_set_en  = 1'b1;
        sb_set_reg = 5'd3;
        step();
        sb_set_en = 1'b0;
        check("sb_commit_en", 32'(reg_write_en), 32'd1);
        check("sb_set_wins", busy_mask, SB_ON ? 32'h00000008 : 32'h0);
        drive(5'd3, 1'b1, 1'b0, 3'b010, 2'd0, 32'h00000034, 32'd0);
        step();
        idle();
        step();
        check("sb_clr_en", 32'(reg_write_en), 32'd1);
        check("sb_clr_data", write_data, 32'h00000034);
        check("sb_clr_mask", busy_mask, 32'h0);

        // Reset mid-operation with two entries buffered
        sb_set_en  = 1'b1;
        sb_set_reg = 5'd5;
        rf_port_busy = 1'b1;
        drive(5'd20, 1'b1, 1'b0, 3'b010, 2'd0, 32'h00000020, 32'd0);
        step();
        sb_set_en = 1'b0;
        drive(5'd21, 1'b1, 1'b0, 3'b010, 2'd0, 32'h00000021, 32'd0);
        step();
        idle();
        check("mid_full_ready", 32'(mem_bus.mem_ready), 32'd0);
        check("mid_mask", busy_mask, SB_ON ? 32'h00000020 : 32'h0);
        reset_n = 1'b0;
        #2;
        check("mid_rst_reg", 32'(write_reg), 32'd0);
        check("mid_rst_data", write_data, 32'd0);
        check("mid_rst_ready", 32'(mem_bus.mem_ready), 32'd1);
        check("mid_rst_mask", busy_mask, 32'd0);
        step();
        reset_n = 1'b1;
        rf_port_busy = 1'b0;
        step();
        check("post_rst_en_a", 32'(reg_write_en), 32'd0);
        step();
        check("post_rst_en_b", 32'(reg_write_en), 32'd0);
        step();
        check("post_rst_en_c", 32'(reg_write_en), 32'd0);
        check("post_rst_reg", 32'(write_reg), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
